// File: rtl/font_buffer_if.sv
// Font port and display read port between the processor/scan-out side and font_buffer.
interface font_buffer_if #(
    parameter int unsigned AW         = 11,
    parameter int unsigned DW         = 4,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          font_en;
    logic [AW-1:0] font_addr;
    logic [DW-1:0] font_data;
    logic          font_clr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          ovf;
    logic [CW-1:0] fifo_cnt;

    modport master (
        output font_en, font_addr, font_data, font_clr, rd_addr,
        input  rd_data, busy, ovf, fifo_cnt
    );

    modport slave (
        input  font_en, font_addr, font_data, font_clr, rd_addr,
        output rd_data, busy, ovf, fifo_cnt
    );
endinterface

// File: rtl/font_buffer.sv
// Character RAM with hardware clear engine and ordered pending-write FIFO.
// Optional FONT_BUFFER_FILL_EN: clear fill value latched from font_data on the clear request.
module font_buffer #(
    parameter int unsigned AW           = 11,
    parameter int unsigned DW           = 4,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter bit          CLR_ON_RESET = 1'b1
) (
    input logic          clk,
    input logic          reset,
    font_buffer_if.slave bus
);
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_ptr;
    logic          rst_clr;
    logic [DW-1:0] fill;
    logic [AW-1:0] q_addr [FIFO_DEPTH];
    logic [DW-1:0] q_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          busy_q;
    logic          ovf_q;
    logic [DW-1:0] rd_q;
    logic [DW-1:0] ram [DEPTH];

    logic          start_clr;
    logic          full;
    logic          direct_wr;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;

    // Request decode and single RAM write-port arbitration: clear, then drain, then direct write.
    always_comb begin
        start_clr = bus.font_clr || (rst_clr && (state == IDLE));
        full      = (cnt == CW'(FIFO_DEPTH));
        direct_wr = (state == IDLE) && (cnt == '0) && !start_clr;
        pop       = (state == DRAIN) && !start_clr && (cnt != '0);
        push_req  = bus.font_en && !direct_wr;
        push      = push_req && (!full || pop);
        drop      = push_req && full && !pop;

        ram_we    = 1'b0;
        ram_waddr = bus.font_addr;
        ram_wdata = bus.font_data;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_ptr;
            ram_wdata = fill;
        end else if (pop) begin
            ram_we    = 1'b1;
            ram_waddr = q_addr[rd_ptr];
            ram_wdata = q_data[rd_ptr];
        end else if (direct_wr && bus.font_en) begin
            ram_we    = 1'b1;
        end
        ram_we = ram_we && reset;
    end

    // Storage array is never reset; only the engine writes it.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // FIFO storage needs no reset: occupancy qualifies every entry.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= bus.font_addr;
            q_data[wr_ptr] <= bus.font_data;
        end
    end

`ifndef FONT_BUFFER_FILL_EN
    assign fill = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            clr_ptr <= '0;
            rst_clr <= CLR_ON_RESET;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            rd_q    <= '0;
`ifdef FONT_BUFFER_FILL_EN
            fill    <= '0;
`endif
        end else begin
            rst_clr <= 1'b0;
            rd_q    <= ram[bus.rd_addr];
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
            if (drop) begin
                ovf_q <= 1'b1;
            end

            if (start_clr) begin
                state   <= CLEAR;
                busy_q  <= 1'b1;
                clr_ptr <= '0;
`ifdef FONT_BUFFER_FILL_EN
                // The power-up clear always fills with zero.
                fill    <= bus.font_clr ? bus.font_data : '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (cnt != '0) begin
                            state  <= DRAIN;
                            busy_q <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        clr_ptr <= clr_ptr + AW'(1);
                        if (&clr_ptr) begin
                            // A write landing on the final clear cycle still needs draining.
                            if ((cnt != '0) || push) begin
                                state <= DRAIN;
                            end else begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end
                        end
                    end
                    DRAIN: begin
                        if ((cnt == CW'(1)) && !push) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rd_data  = rd_q;
    assign bus.busy     = busy_q;
    assign bus.ovf      = ovf_q;
    assign bus.fifo_cnt = cnt;
endmodule

// File: tb/tb_font_buffer.sv
// Self-checking bench for font_buffer: queue/countdown reference model plus directed scenarios.
module tb_font_buffer;
    localparam int unsigned AW    = 11;
    localparam int unsigned DW    = 4;
    localparam int unsigned FD    = 4;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int          MAXW  = 6000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    font_buffer_if #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) bus ();

    font_buffer #(
        .AW(AW), .DW(DW), .FIFO_DEPTH(FD), .CLR_ON_RESET(1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    // Reference model: RAM image, pending-write queue, remaining clear cycles.
    wr_t           q[$];
    logic [DW-1:0] m_ram   [DEPTH];
    bit            m_known [DEPTH];
    int            m_clear_left = 0;
    bit            m_pend = 1'b0;
    bit            m_ovf = 1'b0;
    bit            m_busy = 1'b0;
    bit            m_valid = 1'b0;
    bit            m_rd_known = 1'b0;
    logic [DW-1:0] m_rd = '0;
    logic [DW-1:0] m_fill = '0;
    int            m_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound of %0d cycles expired at %0t", name, MAXW, $time);
    endtask

    always @(posedge clk) begin
        bit   start;
        bit   busy_before;
        wr_t  e;
        logic [AW-1:0] a;
        m_valid = 1'b1;
        if (!reset) begin
            m_clear_left = 0;
            q.delete();
            m_ovf      = 1'b0;
            m_pend     = 1'b1;
            m_rd       = '0;
            m_rd_known = 1'b1;
            m_fill     = '0;
        end else begin
            m_rd        = m_ram[bus.rd_addr];
            m_rd_known  = m_known[bus.rd_addr];
            busy_before = (m_clear_left != 0) || (q.size() != 0);
            start       = bus.font_clr || m_pend;
            m_pend      = 1'b0;
            if (m_clear_left != 0) begin
                a = AW'(DEPTH - 32'(m_clear_left));
                m_ram[a]   = m_fill;
                m_known[a] = 1'b1;
                m_clear_left--;
            end else if ((q.size() != 0) && !start) begin
                e = q.pop_front();
                m_ram[e.a]   = e.d;
                m_known[e.a] = 1'b1;
            end
            if (bus.font_en) begin
                if (!busy_before && !start) begin
                    m_ram[bus.font_addr]   = bus.font_data;
                    m_known[bus.font_addr] = 1'b1;
                end else if (q.size() < FD) begin
                    e.a = bus.font_addr;
                    e.d = bus.font_data;
                    q.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (start) begin
                m_clear_left = DEPTH;
`ifdef FONT_BUFFER_FILL_EN
                m_fill = bus.font_clr ? bus.font_data : '0;
`else
                m_fill = '0;
`endif
            end
        end
        m_busy = (m_clear_left != 0) || (q.size() != 0);
        m_cnt  = q.size();
    end

    // Cycle-by-cycle comparison against the model, just after each active edge.
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("fifo_cnt", 32'(bus.fifo_cnt), 32'(m_cnt));
            check("ovf", 32'(bus.ovf), 32'(m_ovf));
            if (m_rd_known) begin
                check("rd_data", 32'(bus.rd_data), 32'(m_rd));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_check(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bus.rd_addr = a;
        step();
        check(name, 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.font_en   = 1'b1;
        bus.font_addr = a;
        bus.font_data = d;
        step();
        bus.font_en   = 1'b0;
    endtask

    task automatic pulse_clr(input logic [DW-1:0] d);
        bus.font_clr  = 1'b1;
        bus.font_data = d;
        step();
        bus.font_clr  = 1'b0;
        bus.font_data = '0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int k = 0; k < MAXW; k++) begin
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) timeout(name);
    endtask

    task automatic wait_cnt(input string name, input int target);
        bit done = 1'b0;
        for (int k = 0; k < MAXW; k++) begin
            if (32'(bus.fifo_cnt) == target) begin
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) timeout(name);
    endtask

    initial begin
        int n;
        reset         = 1'b0;
        bus.font_en   = 1'b0;
        bus.font_addr = '0;
        bus.font_data = '0;
        bus.font_clr  = 1'b0;
        bus.rd_addr   = '0;
        repeat (3) step();
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_cnt", 32'(bus.fifo_cnt), 32'd0);
        check("reset_ovf", 32'(bus.ovf), 32'd0);
        check("reset_rd", 32'(bus.rd_data), 32'd0);

        // Power-up clear length.
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < MAXW; k++) begin
            step();
            if (!bus.busy) break;
            n++;
        end
        check("power_clear_len", 32'(n), 32'd2048);
        rd_check("rd_0", 11'h000, 4'h0);
        rd_check("rd_3ff", 11'h3FF, 4'h0);
        rd_check("rd_7ff", 11'h7FF, 4'h0);

        // Direct IDLE write, then same-cycle read/write returns old data.
        wr(11'h123, 4'hA);
        rd_check("direct_wr", 11'h123, 4'hA);
        check("direct_busy", 32'(bus.busy), 32'd0);
        bus.rd_addr = 11'h123;
        wr(11'h123, 4'h3);
        check("rw_old_data", 32'(bus.rd_data), 32'hA);
        rd_check("rw_new_data", 11'h123, 4'h3);

        // Writes during clear are queued and drained in order.
        pulse_clr(4'h0);
        step();
        step();
        wr(11'h010, 4'h5);
        wr(11'h010, 4'h6);
        check("queued_cnt", 32'(bus.fifo_cnt), 32'd2);
        check("queued_busy", 32'(bus.busy), 32'd1);
        wait_idle("drain_idle");
        rd_check("order_kept", 11'h010, 4'h6);

        // Overflow: six writes into a four-entry FIFO during clear.
        pulse_clr(4'h0);
        for (int i = 0; i < 6; i++) begin
            wr(AW'(11'h200 + i), DW'(i + 1));
        end
        check("ovf_set", 32'(bus.ovf), 32'd1);
        check("ovf_cnt", 32'(bus.fifo_cnt), 32'd4);
        wait_idle("ovf_idle");
        check("ovf_sticky", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < 4; i++) begin
            rd_check("ovf_kept", AW'(11'h200 + i), DW'(i + 1));
        end
        rd_check("ovf_drop4", 11'h204, 4'h0);
        rd_check("ovf_drop5", 11'h205, 4'h0);

        // Restarted clears: pulses at edge 0, 100 and 1000.
        wr(11'h7FF, 4'hF);
        bus.font_clr = 1'b1;
        n = 0;
        for (int k = 0; k < MAXW; k++) begin
            step();
            bus.font_clr = ((k + 1) == 100) || ((k + 1) == 1000);
            if (!bus.busy) break;
            n++;
        end
        bus.font_clr = 1'b0;
        check("restart_len", 32'(n), 32'd3048);
        rd_check("restart_7ff", 11'h7FF, 4'h0);

        // Clear request mid-drain with a simultaneous write.
        pulse_clr(4'h0);
        for (int i = 0; i < 4; i++) begin
            wr(AW'(11'h300 + i), DW'(i + 7));
        end
        wait_cnt("drain_start", 3);
        bus.font_clr = 1'b1;
        wr(11'h304, 4'hC);
        bus.font_clr = 1'b0;
        check("reclr_busy", 32'(bus.busy), 32'd1);
        check("reclr_cnt", 32'(bus.fifo_cnt), 32'd4);
        wait_idle("reclr_idle");
        rd_check("reclr_300", 11'h300, 4'h0);
        rd_check("reclr_301", 11'h301, 4'h8);
        rd_check("reclr_303", 11'h303, 4'hA);
        rd_check("reclr_304", 11'h304, 4'hC);

        // Reset mid-drain loses pending writes and restarts the clear.
        pulse_clr(4'h0);
        wr(11'h400, 4'h1);
        wr(11'h401, 4'h2);
        wait_cnt("drain2_start", 1);
        reset = 1'b0;
        step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cnt", 32'(bus.fifo_cnt), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        reset = 1'b1;
        step();
        check("rst_reclear", 32'(bus.busy), 32'd1);
        wait_idle("rst_idle");
        rd_check("rst_401", 11'h401, 4'h0);

`ifdef FONT_BUFFER_FILL_EN
        pulse_clr(4'h9);
        wait_idle("fill_idle");
        rd_check("fill_0", 11'h000, 4'h9);
        rd_check("fill_555", 11'h555, 4'h9);
        rd_check("fill_7ff", 11'h7FF, 4'h9);
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        wait_idle("fill_rst_idle");
        rd_check("fill_rst", 11'h555, 4'h0);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
